// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch stage: opcode constants, the fetch FSM
// state encoding and small instruction field helpers.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFU_IDLE  = 2'd0,
        IFU_RUN   = 2'd1,
        IFU_DRAIN = 2'd2,
        IFU_HALT  = 2'd3
    } ifu_state_t;

    function automatic logic [6:0] opcode_of(input logic [31:0] insn);
        return insn[6:0];
    endfunction

    function automatic logic [2:0] funct3_of(input logic [31:0] insn);
        return insn[14:12];
    endfunction

endpackage

// File: rtl/ifu_rsv_buffer.sv
// Reservation buffer for the fetch unit: a slot is reserved with its PC at request
// time and filled in order when memory returns the word; the head pops once filled.
module ifu_rsv_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc,
    input  logic [XLEN-1:0]            alloc_pc,
    input  logic                       fill,
    input  logic [31:0]                fill_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       head_valid,
    output logic [XLEN-1:0]            head_pc,
    output logic [31:0]                head_instr
);
    import riscv_pkg::*;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] pc_d    [DEPTH];
    logic [31:0]     instr_q [DEPTH];
    logic [31:0]     instr_d [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   fill_ptr_q, fill_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        filled_d   = filled_q;
        wr_ptr_d   = wr_ptr_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        if (flush) begin
            filled_d   = '0;
            wr_ptr_d   = '0;
            fill_ptr_d = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
        end else begin
            if (pop) begin
                filled_d[rd_ptr_q] = 1'b0;
                rd_ptr_d           = rd_ptr_q + PW'(1);
            end
            if (alloc) begin
                filled_d[wr_ptr_q] = 1'b0;
                pc_d[wr_ptr_q]     = alloc_pc;
                wr_ptr_d           = wr_ptr_q + PW'(1);
            end
            if (fill) begin
                filled_d[fill_ptr_q] = 1'b1;
                instr_d[fill_ptr_q]  = fill_data;
                fill_ptr_d           = fill_ptr_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(alloc) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filled_q   <= '0;
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            filled_q   <= filled_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Payload storage carries no reset; only filled slots are ever exposed.
    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        instr_q <= instr_d;
    end

    assign count      = cnt_q;
    assign head_valid = (cnt_q != '0) && filled_q[rd_ptr_q];
    assign head_pc    = pc_q[rd_ptr_q];
    assign head_instr = instr_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests, buffers returned words and
// handles redirects by dropping wrong-path responses. Optional macro: IFU_MISALIGN_CHECK_EN.
module instr_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            stall,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7,
    output logic            misaligned_err
);
    import riscv_pkg::*;

    localparam int CW = $clog2(BUF_DEPTH + 1);

    ifu_state_t      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic            misaligned_err_q, misaligned_err_d;

    logic [CW-1:0]   buf_cnt;
    logic            head_valid;
    logic [XLEN-1:0] head_pc;
    logic [31:0]     head_instr;
    logic            running;
    logic            pop_ok;
    logic            req_hs;
    logic            bad_target;
    logic            buf_alloc;
    logic            buf_fill;
    logic [XLEN-1:0] target_aligned;

    assign running        = (state_q == IFU_RUN);
    assign pop_ok         = head_valid & ~stall;
    // A full buffer may still accept a request when the head leaves in the same cycle.
    assign imem_req_valid = running & ((buf_cnt < CW'(BUF_DEPTH)) | pop_ok);
    assign imem_req_addr  = fetch_pc_q;
    assign req_hs         = imem_req_valid & imem_req_ready;
    assign target_aligned = {redirect_target[XLEN-1:2], 2'b00};

`ifdef IFU_MISALIGN_CHECK_EN
    assign bad_target = redirect & (redirect_target[1:0] != 2'b00);
`else
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^redirect_target[1:0];
    assign bad_target         = 1'b0;
`endif

    assign buf_alloc = req_hs & ~redirect;
    assign buf_fill  = imem_rsp_valid & running & ~redirect;

    ifu_rsv_buffer #(
        .XLEN  (XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_rsv_buffer (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .alloc      (buf_alloc),
        .alloc_pc   (fetch_pc_q),
        .fill       (buf_fill),
        .fill_data  (imem_rsp_data),
        .pop        (pop_ok),
        .count      (buf_cnt),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

    // Every response retires one outstanding request, whether it is kept or dropped.
    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        drop_cnt_d       = drop_cnt_q;
        misaligned_err_d = misaligned_err_q;
        inflight_d       = inflight_q + CW'(req_hs) - CW'(imem_rsp_valid);
        case (state_q)
            IFU_IDLE: state_d = IFU_RUN;
            IFU_RUN: begin
                if (req_hs) fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            IFU_DRAIN: begin
                if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
                if (drop_cnt_d == '0) state_d = IFU_RUN;
            end
            default: ;
        endcase
        if (redirect && (state_q != IFU_HALT)) begin
            if (bad_target) begin
                state_d          = IFU_HALT;
                misaligned_err_d = 1'b1;
                drop_cnt_d       = '0;
            end else begin
                fetch_pc_d = target_aligned;
                if (state_q == IFU_RUN) begin
                    drop_cnt_d = inflight_d;
                    state_d    = (inflight_d != '0) ? IFU_DRAIN : IFU_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IFU_IDLE;
            fetch_pc_q       <= RESET_PC;
            inflight_q       <= '0;
            drop_cnt_q       <= '0;
            misaligned_err_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            fetch_pc_q       <= fetch_pc_d;
            inflight_q       <= inflight_d;
            drop_cnt_q       <= drop_cnt_d;
            misaligned_err_q <= misaligned_err_d;
        end
    end

    // Decode sees all-zero fields while nothing is valid, which it treats as a no-write op.
    assign instr_valid    = head_valid;
    assign instr          = head_valid ? head_instr : 32'h0;
    assign instr_pc       = head_valid ? head_pc : '0;
    assign instr_pc_plus4 = head_valid ? (head_pc + XLEN'(4)) : '0;
    assign op             = opcode_of(instr);
    assign funct3         = funct3_of(instr);
    assign funct7         = instr[30];
    assign misaligned_err = misaligned_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: an in-order imem model with variable latency and a
// program-order reference of expected PCs/words; directed scenarios then random traffic.
module tb_instr_fetch_unit;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic        misaligned_err;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN      (XLEN),
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .stall           (stall),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_pc_plus4  (instr_pc_plus4),
        .op              (op),
        .funct3          (funct3),
        .funct7          (funct7),
        .misaligned_err  (misaligned_err)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } mrsp_t;

    mrsp_t       mq[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    int          rsp_pct = 100;
    logic        no_rsp = 1'b0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_req_pc = RESET_PC;
    int          hs_cnt = 0;
    int          pop_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive the memory response, check what the edge will do, update the model.
    task automatic step();
        logic        hs;
        logic        pop;
        logic [31:0] w;
        if (!no_rsp && mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        if (!instr_valid) begin
            chk("gated_fields", 64'({instr, op, funct3, funct7}), 64'(0));
            chk("gated_pc", 64'({instr_pc, instr_pc_plus4}), 64'(0));
        end
        hs  = imem_req_valid && imem_req_ready;
        pop = instr_valid && !stall && !redirect;
        if (hs) chk("req_addr", 64'(imem_req_addr), 64'(exp_req_pc));
        if (pop) begin
            w = mem_word(exp_pc);
            chk("instr_pc", 64'(instr_pc), 64'(exp_pc));
            chk("instr", 64'(instr), 64'(w));
            chk("fields", 64'({op, funct3, funct7}), 64'({w[6:0], w[14:12], w[30]}));
            chk("pc_plus4", 64'(instr_pc_plus4), 64'(exp_pc + 32'd4));
            exp_pc = exp_pc + 32'd4;
            pop_cnt++;
        end
        if (redirect) begin
            exp_pc     = {redirect_target[31:2], 2'b00};
            exp_req_pc = {redirect_target[31:2], 2'b00};
        end else if (hs) begin
            exp_req_pc = exp_req_pc + 32'd4;
        end
        if (imem_rsp_valid) void'(mq.pop_front());
        if (hs) begin
            mq.push_back('{data: mem_word(imem_req_addr), due: cyc + lat});
            hs_cnt++;
        end
        chk("outstanding_le_depth", 64'(mq.size() <= DEPTH), 64'(1));
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect       = 1'b0;
        stall          = 1'b0;
        imem_rsp_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        mq.delete();
        exp_pc     = RESET_PC;
        exp_req_pc = RESET_PC;
        rst        = 1'b0;
        #1;
        chk("rst_req", 64'({imem_req_valid, instr_valid, misaligned_err}), 64'(0));
        chk("rst_addr", 64'(imem_req_addr), 64'(RESET_PC));
        chk("rst_fields", 64'({instr, op, funct3, funct7}), 64'(0));
        chk("rst_pc", 64'({instr_pc, instr_pc_plus4}), 64'(0));
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] pc);
        int k = 0;
        while (!instr_valid && k < 40) begin
            step();
            k++;
        end
        chk(tag, 64'({instr_valid, instr_pc}), 64'({1'b1, pc}));
    endtask

    task automatic random_phase(input int n);
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            stall           = ($urandom_range(99) < 30);
            imem_req_ready  = ($urandom_range(99) < 75);
            lat             = $urandom_range(3, 1);
            rsp_pct         = 70;
            redirect        = ($urandom_range(99) < 4);
            r               = $urandom;
            redirect_target = r & 32'h0000_0FFC;
            step();
        end
        redirect       = 1'b0;
        stall          = 1'b0;
        imem_req_ready = 1'b1;
        rsp_pct        = 100;
        lat            = 1;
    endtask

    initial begin
        logic [31:0] w0;
        int          h0;
        int          k;

        // Reset and back-to-back fetch with single-cycle memory.
        imem_req_ready = 1'b1;
        lat            = 1;
        rsp_pct        = 100;
        do_reset();
        chk("t1_idle_no_req", 64'(imem_req_valid), 64'(0));
        step();
        chk("t1_req0", 64'({imem_req_valid, imem_req_addr}), 64'({1'b1, 32'h0}));
        step();
        chk("t1_req4", 64'({imem_req_valid, imem_req_addr}), 64'({1'b1, 32'h4}));
        chk("t1_not_valid_c2", 64'(instr_valid), 64'(0));
        step();
        w0 = mem_word(32'h0);
        chk("t1_valid_c3", 64'({instr_valid, instr_pc}), 64'({1'b1, 32'h0}));
        chk("t1_op", 64'(op), 64'(w0[6:0]));
        chk("t1_req8", 64'({imem_req_valid, imem_req_addr}), 64'({1'b1, 32'h8}));
        step();
        chk("t1_pc4", 64'({instr_valid, instr_pc}), 64'({1'b1, 32'h4}));
        step();
        chk("t1_pc8", 64'({instr_valid, instr_pc}), 64'({1'b1, 32'h8}));

        // Decode stalls for four cycles.
        stall = 1'b1;
        h0    = hs_cnt;
        repeat (4) step();
        chk("t2_allocs_le_2", 64'((hs_cnt - h0) <= 2), 64'(1));
        #1;
        chk("t2_req_blocked", 64'(imem_req_valid), 64'(0));
        chk("t2_head_kept", 64'({instr_valid, instr_pc}), 64'({1'b1, exp_pc}));
        stall = 1'b0;
        repeat (6) step();

        // Redirect with two requests outstanding and no same-cycle response.
        lat = 3;
        k   = 0;
        while (mq.size() != 2 && k < 20) begin
            step();
            k++;
        end
        chk("t3_two_in_flight", 64'(mq.size()), 64'(2));
        no_rsp          = 1'b1;
        redirect        = 1'b1;
        redirect_target = 32'h0000_0100;
        step();
        redirect = 1'b0;
        no_rsp   = 1'b0;
        #1;
        chk("t3_flushed", 64'({instr_valid, imem_req_valid}), 64'(0));
        chk("t3_fetch_pc", 64'(imem_req_addr), 64'(32'h100));
        wait_valid("t3_first_pc", 32'h0000_0100);

        // Redirect coinciding with both a response and a handshake.
        lat = 1;
        repeat (8) step();
        #1;
        chk("t4_pre", 64'({imem_req_valid, 1'(mq.size() == 1), 1'(mq[0].due <= cyc)}), 64'(3'b111));
        redirect        = 1'b1;
        redirect_target = 32'h0000_0200;
        step();
        redirect = 1'b0;
        #1;
        chk("t4_fetch_pc", 64'(imem_req_addr), 64'(32'h200));
        chk("t4_drain", 64'({imem_req_valid, instr_valid}), 64'(0));
        chk("t4_outstanding", 64'(mq.size()), 64'(1));
        wait_valid("t4_first_pc", 32'h0000_0200);

        // Misaligned redirect target.
        repeat (4) step();
        redirect        = 1'b1;
        redirect_target = 32'h0000_0102;
        step();
        redirect = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
        chk("t5_err_set", 64'(misaligned_err), 64'(1));
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t5_halted", 64'({imem_req_valid, instr_valid}), 64'(0));
            step();
        end
        chk("t5_err_sticky", 64'(misaligned_err), 64'(1));
        do_reset();
`else
        chk("t5_no_err", 64'(misaligned_err), 64'(0));
        chk("t5_aligned_pc", 64'(imem_req_addr), 64'(32'h100));
        wait_valid("t5_first_pc", 32'h0000_0100);
`endif

        // Random traffic, then a reset in the middle of a live stream.
        random_phase(250);
        repeat (3) step();
        do_reset();
        chk("t6_restart_op", 64'(op), 64'(0));
        wait_valid("t6_restart_pc", RESET_PC);
        h0 = pop_cnt;
        random_phase(250);
        repeat (10) step();
        chk("progress", 64'((pop_cnt - h0) > 20), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
